fpnew_result_buffer: RTL
========================

FPNEW_RESULT_BUFFER -- requirements
Module: fpnew_result_buffer

Interface
REQ-001 SHALL have parameter Width, default 64, result bit width; equals the FPU datapath width.
REQ-002 SHALL have parameter Depth, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have parameter type TagType, default logic, opaque tag carried with each result.
REQ-004 SHALL have port clk_i, input, 1, single clock.
REQ-005 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, 1, synchronous discard of all buffered entries.
REQ-007 SHALL have port in_result_i, input, Width, result from the FPU top.
REQ-008 SHALL have port in_status_i, input, fpnew_pkg::status_t (5: NV,DZ,OF,UF,NX), exception flags of the result.
REQ-009 SHALL have port in_tag_i, input, TagType, tag of the result.
REQ-010 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1), upstream handshake.
REQ-011 SHALL have ports out_result_o (output, Width), out_status_o (output, status_t) and out_tag_o (output, TagType), head entry.
REQ-012 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1), downstream handshake.
REQ-013 SHALL have port fflags_o, output, status_t, sticky OR of status of all dequeued results.
REQ-014 SHALL have port fflags_clr_i, input, 1, clears fflags_o.
REQ-015 SHALL have port usage_o, output, $clog2(Depth)+1, number of valid entries.
REQ-016 SHALL have port busy_o, output, 1, high when usage_o != 0.

Function
REQ-017 SHALL operate as an in-order FIFO: push on in_valid_i & in_ready_o; pop on out_valid_o & out_ready_i.
REQ-018 SHALL set in_ready_o = (usage_o < Depth); a full buffer SHALL NOT accept a push, even with a simultaneous pop.
REQ-019 SHALL NOT fall through: an entry pushed in cycle N SHALL appear at the outputs with out_valid_o high no earlier than cycle N+1.
REQ-020 SHALL set out_valid_o = (usage_o != 0) and drive out_* from the head entry. out_* SHALL be don't-care when out_valid_o is low.
REQ-021 SHALL hold out_* stable while out_valid_o & !out_ready_i.
REQ-022 On a simultaneous push and pop when not full and not empty, SHALL keep usage_o unchanged and advance both pointers.
REQ-023 SHALL wrap the read and write pointers modulo Depth. Full and empty SHALL be distinguished by the count, not by pointer equality.
REQ-024 On each pop, SHALL set fflags_o <= fflags_o | out_status_o.
REQ-025 When fflags_clr_i and a pop occur in the same cycle, SHALL set fflags_o <= out_status_o. When fflags_clr_i occurs alone, SHALL set fflags_o <= 0.
REQ-026 On flush_i, SHALL set usage_o and both pointers to 0 in the next cycle.
REQ-027 flush_i SHALL take priority: a push or pop in the same cycle has no effect on the buffer contents.
REQ-028 flush_i SHALL NOT modify fflags_o; a pop coincident with flush_i SHALL NOT accumulate flags.
REQ-029 SHALL NOT combinationally depend on out_ready_i for in_ready_o, and SHALL NOT combinationally depend on in_valid_i for out_valid_o.

Reset
REQ-030 On rst_ni low, SHALL asynchronously clear the pointers, usage_o, fflags_o, out_valid_o and busy_o to 0, and drive in_ready_o to 1.
REQ-031 SHALL NOT reset the data storage (result, status, tag). Reset mid-transfer SHALL discard all entries.

Structure
REQ-032 SHALL use status_t from fpnew_pkg. No new package types SHALL be added.
REQ-033 SHALL be a single module with no sub-modules, and SHALL elaborate an assertion that Depth is a power of two >= 2.

Verification
REQ-034 Scenario 1: push results A=0x3FF0000000000000 (status 0) and B (status NX=1) with out_ready_i=1 -> A then B appear in order, each one cycle after its push; fflags_o ends at 5'b00001.
REQ-035 Scenario 2: with out_ready_i=0, push until in_ready_o=0 -> usage_o=4 and the 5th push is refused. Then push and pop in the same cycle -> the pop completes and the push is refused.
REQ-036 Scenario 3: run 10 push/pop cycles with usage_o held at 2 -> pointers wrap past Depth with order preserved and usage_o constant at 2.
REQ-037 Scenario 4: with 3 entries buffered, assert flush_i together with a push -> next cycle usage_o=0, out_valid_o=0, busy_o=0, and fflags_o unchanged.
REQ-038 Scenario 5: with fflags_o=5'b10000, assert fflags_clr_i together with a pop of status OF (5'b00100) -> fflags_o=5'b00100.
REQ-039 Scenario 6: deassert rst_ni asynchronously mid-stream with 2 entries held -> outputs immediately take their reset values, and the first post-reset push is delivered correctly.

Source files
------------

// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared FPU types used by the result buffer.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_result_buffer.sv
// fpnew_result_buffer: in-order FIFO for FPU results with sticky exception flags.
// Storage is not reset; validity is tracked solely by the occupancy count.
module fpnew_result_buffer import fpnew_pkg::*; #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [Width-1:0]         in_result_i,
    input  status_t                  in_status_i,
    input  TagType                   in_tag_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [Width-1:0]         out_result_o,
    output status_t                  out_status_o,
    output TagType                   out_tag_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output status_t                  fflags_o,
    input  logic                     fflags_clr_i,
    output logic [$clog2(Depth):0]   usage_o,
    output logic                     busy_o
);

    localparam int unsigned AW = $clog2(Depth);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("fpnew_result_buffer: Depth must be a power of two >= 2");
    end

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      usage_q, usage_d;
    status_t          fflags_q, fflags_d;
    logic [Width-1:0] result_q [Depth];
    status_t          status_q [Depth];
    TagType           tag_q    [Depth];
    logic             push, pop, pop_eff;

    assign in_ready_o   = usage_q != (AW+1)'(Depth);
    assign out_valid_o  = usage_q != '0;
    assign busy_o       = out_valid_o;
    assign usage_o      = usage_q;
    assign fflags_o     = fflags_q;
    assign out_result_o = result_q[rd_ptr_q];
    assign out_status_o = status_q[rd_ptr_q];
    assign out_tag_o    = tag_q[rd_ptr_q];

    assign push    = in_valid_i & in_ready_o;
    assign pop     = out_valid_o & out_ready_i;
    // A pop swallowed by a flush must not contribute to the sticky flags.
    assign pop_eff = pop & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
        end else begin
            wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            usage_d  = usage_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_comb begin
        fflags_d = fflags_clr_i ? '0 : fflags_q;
        fflags_d = pop_eff ? (fflags_d | out_status_o) : fflags_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            result_q[wr_ptr_q] <= in_result_i;
            status_q[wr_ptr_q] <= in_status_i;
            tag_q[wr_ptr_q]    <= in_tag_i;
        end
    end

endmodule
